// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control FSM and the datapath:
// IR fields and the zero flag going in, enables/selects/debug state coming out.
interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic [6:0] estado;
  logic       PCWrite;
  logic       IMemRead;
  logic       LoadIR;
  logic       LoadOldPC;
  logic       LoadA;
  logic       LoadB;
  logic       LoadAluOut;
  logic       LoadMDR;
  logic       DMemWr;
  logic       RegWrite;
  logic [1:0] AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluFct;
  logic       PCSrc;
  logic [1:0] MemToReg;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, zero,
    output estado, PCWrite, IMemRead, LoadIR, LoadOldPC, LoadA, LoadB, LoadAluOut,
           LoadMDR, DMemWr, RegWrite, AluSrcA, AluSrcB, AluFct, PCSrc, MemToReg, illegal
  );

  modport slave (
    output opcode, funct3, funct7, zero,
    input  estado, PCWrite, IMemRead, LoadIR, LoadOldPC, LoadA, LoadB, LoadAluOut,
           LoadMDR, DMemWr, RegWrite, AluSrcA, AluSrcB, AluFct, PCSrc, MemToReg, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle main control FSM for the RISC-V datapath (add, sub, addi, ld, sd, beq, bne, lui).
// Outputs are Moore-decoded from the state register; only PCWrite in BRANCH depends on zero.
module control_unit (
  input  logic          clock,
  input  logic          reset,
  control_unit_if.master cu
);

  typedef enum logic [6:0] {
    RESET    = 7'd0,
    FETCH1   = 7'd1,
    FETCH2   = 7'd2,
    DECODE   = 7'd3,
    EXEC_R   = 7'd4,
    EXEC_I   = 7'd5,
    WB_ALU   = 7'd6,
    MEM_ADDR = 7'd7,
    LD_READ  = 7'd8,
    LD_WB    = 7'd9,
    SD_WRITE = 7'd10,
    BRANCH   = 7'd11,
    LUI      = 7'd12,
    ILLEGAL  = 7'd127
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] FCT_ADD = 3'b001;
  localparam logic [2:0] FCT_SUB = 3'b010;

  state_e state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:  state_d = FETCH1;
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = DECODE;
      DECODE: begin
        case (cu.opcode)
          OP_R:   state_d = (cu.funct3 == 3'b000 &&
                             (cu.funct7 == 7'b0000000 || cu.funct7 == 7'b0100000))
                            ? EXEC_R : ILLEGAL;
          OP_I:   state_d = (cu.funct3 == 3'b000) ? EXEC_I : ILLEGAL;
          OP_LD,
          OP_SD:  state_d = (cu.funct3 == 3'b011) ? MEM_ADDR : ILLEGAL;
          OP_BR:  state_d = (cu.funct3 == 3'b000 || cu.funct3 == 3'b001) ? BRANCH : ILLEGAL;
          OP_LUI: state_d = LUI;
          default: state_d = ILLEGAL;
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR: state_d = (cu.opcode == OP_LD) ? LD_READ : SD_WRITE;
      LD_READ:  state_d = LD_WB;
      WB_ALU, LD_WB, SD_WRITE, BRANCH, LUI: state_d = FETCH1;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = ILLEGAL;
    endcase
  end

  always_comb begin
    cu.estado     = state_q;
    cu.PCWrite    = 1'b0;
    cu.IMemRead   = 1'b0;
    cu.LoadIR     = 1'b0;
    cu.LoadOldPC  = 1'b0;
    cu.LoadA      = 1'b0;
    cu.LoadB      = 1'b0;
    cu.LoadAluOut = 1'b0;
    cu.LoadMDR    = 1'b0;
    cu.DMemWr     = 1'b0;
    cu.RegWrite   = 1'b0;
    cu.AluSrcA    = '0;
    cu.AluSrcB    = '0;
    cu.AluFct     = '0;
    cu.PCSrc      = 1'b0;
    cu.MemToReg   = '0;
    cu.illegal    = 1'b0;
    case (state_q)
      FETCH2: begin
        cu.LoadIR    = 1'b1;
        cu.LoadOldPC = 1'b1;
        cu.PCWrite   = 1'b1;
        cu.AluSrcA   = 2'b00;
        cu.AluSrcB   = 2'b01;
        cu.AluFct    = FCT_ADD;
      end
      DECODE: begin
        cu.LoadA      = 1'b1;
        cu.LoadB      = 1'b1;
        cu.LoadAluOut = 1'b1;
        cu.AluSrcA    = 2'b10;
        cu.AluSrcB    = 2'b10;
        cu.AluFct     = FCT_ADD;
      end
      EXEC_R: begin
        cu.AluSrcA    = 2'b01;
        cu.AluSrcB    = 2'b00;
        cu.LoadAluOut = 1'b1;
        cu.AluFct     = cu.funct7[5] ? FCT_SUB : FCT_ADD;
      end
      EXEC_I, MEM_ADDR: begin
        cu.AluSrcA    = 2'b01;
        cu.AluSrcB    = 2'b10;
        cu.AluFct     = FCT_ADD;
        cu.LoadAluOut = 1'b1;
      end
      WB_ALU: cu.RegWrite = 1'b1;
      LD_READ: cu.LoadMDR = 1'b1;
      LD_WB: begin
        cu.RegWrite = 1'b1;
        cu.MemToReg = 2'b01;
      end
      SD_WRITE: cu.DMemWr = 1'b1;
      BRANCH: begin
        // Compare-and-redirect: ALU does A-B for zero, PC loads the target held in AluOut.
        cu.AluSrcA = 2'b01;
        cu.AluSrcB = 2'b00;
        cu.AluFct  = FCT_SUB;
        cu.PCSrc   = 1'b1;
        cu.PCWrite = (cu.funct3 == 3'b000 &&  cu.zero) ||
                     (cu.funct3 == 3'b001 && !cu.zero);
      end
      LUI: begin
        cu.RegWrite = 1'b1;
        cu.MemToReg = 2'b10;
      end
      ILLEGAL: cu.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class state by state and
// compares the full output vector against hand-written per-state constants.
module tb_control_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pc     = 0;

  control_unit_if cu ();

  control_unit dut (
    .clock (clock),
    .reset (reset),
    .cu    (cu.master)
  );

  always #5 clock = ~clock;

  // Tiny PC model driven by the strobes (sequential increment path only).
  always @(posedge clock or posedge reset) begin
    if (reset) pc <= 0;
    else if (cu.PCWrite && !cu.PCSrc) pc <= pc + 4;
  end

  // {estado, 10 strobes, AluSrcA, AluSrcB, AluFct, PCSrc, MemToReg, illegal}
  // strobe order: PCWrite IMemRead LoadIR LoadOldPC LoadA LoadB LoadAluOut LoadMDR DMemWr RegWrite
  logic [27:0] obs;
  assign obs = {cu.estado, cu.PCWrite, cu.IMemRead, cu.LoadIR, cu.LoadOldPC, cu.LoadA, cu.LoadB,
                cu.LoadAluOut, cu.LoadMDR, cu.DMemWr, cu.RegWrite, cu.AluSrcA, cu.AluSrcB,
                cu.AluFct, cu.PCSrc, cu.MemToReg, cu.illegal};

  function automatic logic [27:0] mk(input logic [6:0] st, input logic [9:0] stb,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] fct, input logic pcs,
                                     input logic [1:0] m2r, input logic ill);
    return {st, stb, sa, sb, fct, pcs, m2r, ill};
  endfunction

  localparam logic [27:0] E_RESET  = {7'd0,   10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_F1     = {7'd1,   10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_F2     = {7'd2,   10'b1011000000, 2'b00, 2'b01, 3'b001, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_DEC    = {7'd3,   10'b0000111000, 2'b10, 2'b10, 3'b001, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_ADD    = {7'd4,   10'b0000001000, 2'b01, 2'b00, 3'b001, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_SUB    = {7'd4,   10'b0000001000, 2'b01, 2'b00, 3'b010, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_EXI    = {7'd5,   10'b0000001000, 2'b01, 2'b10, 3'b001, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_WB     = {7'd6,   10'b0000000001, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_MADDR  = {7'd7,   10'b0000001000, 2'b01, 2'b10, 3'b001, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_LDRD   = {7'd8,   10'b0000000100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_LDWB   = {7'd9,   10'b0000000001, 2'b00, 2'b00, 3'b000, 1'b0, 2'b01, 1'b0};
  localparam logic [27:0] E_SDW    = {7'd10,  10'b0000000010, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [27:0] E_BR_T   = {7'd11,  10'b1000000000, 2'b01, 2'b00, 3'b010, 1'b1, 2'b00, 1'b0};
  localparam logic [27:0] E_BR_N   = {7'd11,  10'b0000000000, 2'b01, 2'b00, 3'b010, 1'b1, 2'b00, 1'b0};
  localparam logic [27:0] E_LUI    = {7'd12,  10'b0000000001, 2'b00, 2'b00, 3'b000, 1'b0, 2'b10, 1'b0};
  localparam logic [27:0] E_ILL    = {7'd127, 10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [27:0] exp);
    @(negedge clock);
    check(tag, {4'h0, obs}, {4'h0, exp});
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z);
    cu.opcode = op;
    cu.funct3 = f3;
    cu.funct7 = f7;
    cu.zero   = z;
  endtask

  task automatic fetch_decode(input string tag);
    expect_state({tag, ".f1"}, E_F1);
    expect_state({tag, ".f2"}, E_F2);
    expect_state({tag, ".dec"}, E_DEC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_ir(7'b0110011, 3'b000, 7'b0000000, 1'b0);
    reset = 1'b1;
    #1;
    check("rst.async", {4'h0, obs}, {4'h0, E_RESET});
    repeat (3) expect_state("rst.hold", E_RESET);
    reset = 1'b0;

    // add
    fetch_decode("add");
    check("pc.after_fetch", pc, 4);
    expect_state("add.ex", E_ADD);
    expect_state("add.wb", E_WB);

    // sub
    set_ir(7'b0110011, 3'b000, 7'b0100000, 1'b0);
    fetch_decode("sub");
    expect_state("sub.ex", E_SUB);
    expect_state("sub.wb", E_WB);

    // addi
    set_ir(7'b0010011, 3'b000, 7'b0000000, 1'b0);
    fetch_decode("addi");
    expect_state("addi.ex", E_EXI);
    expect_state("addi.wb", E_WB);

    // ld x5,8(x1)
    set_ir(7'b0000011, 3'b011, 7'b0000000, 1'b0);
    fetch_decode("ld");
    expect_state("ld.addr", E_MADDR);
    expect_state("ld.read", E_LDRD);
    expect_state("ld.wb", E_LDWB);

    // sd
    set_ir(7'b0100011, 3'b011, 7'b0000000, 1'b0);
    fetch_decode("sd");
    expect_state("sd.addr", E_MADDR);
    expect_state("sd.write", E_SDW);

    // branches: beq z=1 taken, beq z=0 not, bne z=1 not, bne z=0 taken
    set_ir(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    fetch_decode("beq1");
    expect_state("beq1.br", E_BR_T);
    set_ir(7'b1100011, 3'b000, 7'b0000000, 1'b0);
    fetch_decode("beq0");
    expect_state("beq0.br", E_BR_N);
    set_ir(7'b1100011, 3'b001, 7'b0000000, 1'b1);
    fetch_decode("bne1");
    expect_state("bne1.br", E_BR_N);
    set_ir(7'b1100011, 3'b001, 7'b0000000, 1'b0);
    fetch_decode("bne0");
    expect_state("bne0.br", E_BR_T);

    // lui
    set_ir(7'b0110111, 3'b101, 7'b1010101, 1'b0);
    fetch_decode("lui");
    expect_state("lui.wb", E_LUI);

    // R-type with unsupported funct7 falls into ILLEGAL
    set_ir(7'b0110011, 3'b000, 7'b0000001, 1'b0);
    fetch_decode("badr");
    expect_state("badr.ill", E_ILL);

    // illegal opcode held until reset
    reset = 1'b1;
    expect_state("rst2", E_RESET);
    reset = 1'b0;
    set_ir(7'b1111111, 3'b000, 7'b0000000, 1'b0);
    fetch_decode("ill");
    repeat (10) expect_state("ill.hold", E_ILL);

    // addi with funct3=001 is illegal
    reset = 1'b1;
    expect_state("rst3", E_RESET);
    reset = 1'b0;
    set_ir(7'b0010011, 3'b001, 7'b0000000, 1'b0);
    fetch_decode("addi_f3");
    expect_state("addi_f3.ill", E_ILL);

    // reset between edges during SD_WRITE
    reset = 1'b1;
    expect_state("rst4", E_RESET);
    reset = 1'b0;
    set_ir(7'b0100011, 3'b011, 7'b0000000, 1'b0);
    fetch_decode("sd2");
    expect_state("sd2.addr", E_MADDR);
    expect_state("sd2.write", E_SDW);
    #2;
    reset = 1'b1;
    #1;
    check("sd2.rst.dmemwr", {31'd0, cu.DMemWr}, 32'd0);
    check("sd2.rst.estado", {25'd0, cu.estado}, 32'd0);
    expect_state("sd2.rst.hold", E_RESET);
    reset = 1'b0;
    set_ir(7'b0110011, 3'b000, 7'b0000000, 1'b0);
    fetch_decode("restart");
    check("pc.restart", pc, 4);
    expect_state("restart.ex", E_ADD);
    expect_state("restart.wb", E_WB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
